// File: rtl/m_dm_slave_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : m_dm_slave_if
// Description : M-stage data-memory request/response bundle.
//               master : pipeline side (drives req/we/op/addr/wdata/pc)
//               slave  : memory responder (drives busy/ready/rdata/err and
//                        the write-log record wlog_*)
// Revision    : 1.0 - initial release
// ============================================================================
interface m_dm_slave_if;
  logic        req;
  logic        we;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] pc;
  logic        busy;
  logic        ready;
  logic [31:0] rdata;
  logic        err;
  logic        wlog_valid;
  logic [31:0] wlog_pc;
  logic [31:0] wlog_addr;
  logic [31:0] wlog_data;

  modport master (
    output req, we, op, addr, wdata, pc,
    input  busy, ready, rdata, err, wlog_valid, wlog_pc, wlog_addr, wlog_data
  );

  modport slave (
    input  req, we, op, addr, wdata, pc,
    output busy, ready, rdata, err, wlog_valid, wlog_pc, wlog_addr, wlog_data
  );
endinterface
`default_nettype wire

// File: rtl/m_dm_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : m_dm_slave
// Description : Multi-cycle data-memory responder for M-stage loads/stores.
//               Accepts one request per handshake, waits WAIT cycles, then
//               pulses ready with the load result / error flag and, for
//               committed stores, a write-log record.
// Ports       : clk   - clock, rising edge
//               reset - synchronous, active-high
//               bus   - m_dm_slave_if.slave (request in, response out)
// Parameters  : ADDR_W - word-address width (2^ADDR_W 32-bit words)
//               WAIT   - wait states between accept and response (0..15)
// Revision    : 1.0 - initial release
// ============================================================================
module m_dm_slave #(
  parameter int ADDR_W = 12,
  parameter int WAIT   = 2
) (
  input  logic        clk,
  input  logic        reset,
  m_dm_slave_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] c_CNT_INIT = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);
  // With no wait states the commit happens on the accept edge itself, so the
  // commit datapath must look at the live inputs instead of the captures.
  localparam bit         c_DIRECT   = (WAIT == 0);

  state_t      r_state, w_next;
  logic        w_accept, w_commit;
  logic [3:0]  r_cnt;

  logic        r_we;
  logic [2:0]  r_op;
  logic [31:0] r_addr, r_wdata, r_pc;

  logic [31:0] r_mem [2**ADDR_W];

  logic        r_ready, r_err, r_wlog_valid;
  logic [31:0] r_rdata, r_wlog_pc, r_wlog_addr, r_wlog_data;

  logic        w_c_we;
  logic [2:0]  w_c_op;
  logic [31:0] w_c_addr, w_c_wdata, w_c_pc;
  logic [ADDR_W-1:0] w_idx;
  logic [31:0] w_word, w_load, w_merge;
  logic [15:0] w_half;
  logic [7:0]  w_byte;
  logic        w_err;

  assign w_accept = bus.req & ((r_state == S_IDLE) | (r_state == S_RESP));

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state; w_commit marks the edge that enters RESP
  always_comb begin
    w_next   = r_state;
    w_commit = 1'b0;
    case (r_state)
      S_IDLE, S_RESP: begin
        if (w_accept) begin
          if (c_DIRECT) begin
            w_next   = S_RESP;
            w_commit = 1'b1;
          end else begin
            w_next   = S_WAIT;
          end
        end else begin
          w_next = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next   = S_RESP;
          w_commit = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_c_we    = c_DIRECT ? bus.we    : r_we;
  assign w_c_op    = c_DIRECT ? bus.op    : r_op;
  assign w_c_addr  = c_DIRECT ? bus.addr  : r_addr;
  assign w_c_wdata = c_DIRECT ? bus.wdata : r_wdata;
  assign w_c_pc    = c_DIRECT ? bus.pc    : r_pc;

  assign w_idx  = w_c_addr[ADDR_W+1:2];
  assign w_word = r_mem[w_idx];
  assign w_half = w_c_addr[1] ? w_word[31:16] : w_word[15:0];

  // Alignment / legality, load extraction and store merge
  always_comb begin
    w_err   = 1'b0;
    w_load  = 32'd0;
    w_merge = w_word;
    w_byte  = w_word[7:0];
    case (w_c_addr[1:0])
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      2'd3:    w_byte = w_word[31:24];
      default: w_byte = w_word[7:0];
    endcase
    case (w_c_op)
      3'd0: begin
        w_err   = (w_c_addr[1:0] != 2'd0);
        w_load  = w_word;
        w_merge = w_c_wdata;
      end
      3'd1, 3'd2: begin
        w_err  = w_c_addr[0];
        w_load = (w_c_op == 3'd1) ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
        if (w_c_addr[1]) w_merge[31:16] = w_c_wdata[15:0];
        else             w_merge[15:0]  = w_c_wdata[15:0];
      end
      3'd3, 3'd4: begin
        w_load = (w_c_op == 3'd3) ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
        case (w_c_addr[1:0])
          2'd0:    w_merge[7:0]   = w_c_wdata[7:0];
          2'd1:    w_merge[15:8]  = w_c_wdata[7:0];
          2'd2:    w_merge[23:16] = w_c_wdata[7:0];
          default: w_merge[31:24] = w_c_wdata[7:0];
        endcase
      end
      default: w_err = 1'b1;
    endcase
  end

  // Request capture, wait counter, commit and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= 4'd0;
      r_we         <= 1'b0;
      r_op         <= 3'd0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_pc         <= 32'd0;
      r_ready      <= 1'b0;
      r_err        <= 1'b0;
      r_rdata      <= 32'd0;
      r_wlog_valid <= 1'b0;
      r_wlog_pc    <= 32'd0;
      r_wlog_addr  <= 32'd0;
      r_wlog_data  <= 32'd0;
      for (int i = 0; i < 2**ADDR_W; i++) r_mem[i] <= 32'd0;
    end else begin
      r_ready      <= w_commit;
      r_wlog_valid <= w_commit & w_c_we & ~w_err;
      if (w_accept) begin
        r_we    <= bus.we;
        r_op    <= bus.op;
        r_addr  <= bus.addr;
        r_wdata <= bus.wdata;
        r_pc    <= bus.pc;
        r_cnt   <= c_CNT_INIT;
      end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit) begin
        r_err   <= w_err;
        r_rdata <= (w_c_we | w_err) ? 32'd0 : w_load;
        if (w_c_we & ~w_err) begin
          r_mem[w_idx] <= w_merge;
          r_wlog_pc    <= w_c_pc;
          r_wlog_addr  <= {w_c_addr[31:2], 2'b00};
          r_wlog_data  <= w_merge;
        end
      end
    end
  end

  assign bus.busy       = (r_state == S_WAIT);
  assign bus.ready      = r_ready;
  assign bus.rdata      = r_rdata;
  assign bus.err        = r_err;
  assign bus.wlog_valid = r_wlog_valid;
  assign bus.wlog_pc    = r_wlog_pc;
  assign bus.wlog_addr  = r_wlog_addr;
  assign bus.wlog_data  = r_wlog_data;

endmodule
`default_nettype wire

// File: tb/tb_m_dm_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_m_dm_slave
// Description : Directed self-checking bench for m_dm_slave. Three instances
//               (WAIT=2, WAIT=3, WAIT=0) share one stimulus bus; dut selects
//               which instance receives req and whose outputs are observed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_m_dm_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst2, rst3, rst0;
  logic [2:0]  req_v;
  logic        we;
  logic [2:0]  op;
  logic [31:0] addr, wdata, pc;
  int          dut;

  int n_vec, n_miss;

  m_dm_slave_if b2 ();
  m_dm_slave_if b3 ();
  m_dm_slave_if b0 ();

  assign b2.req = req_v[0]; assign b2.we = we; assign b2.op = op;
  assign b2.addr = addr;    assign b2.wdata = wdata; assign b2.pc = pc;
  assign b3.req = req_v[1]; assign b3.we = we; assign b3.op = op;
  assign b3.addr = addr;    assign b3.wdata = wdata; assign b3.pc = pc;
  assign b0.req = req_v[2]; assign b0.we = we; assign b0.op = op;
  assign b0.addr = addr;    assign b0.wdata = wdata; assign b0.pc = pc;

  m_dm_slave #(.ADDR_W(12), .WAIT(2)) u_dut_w2 (.clk(clk), .reset(rst2), .bus(b2));
  m_dm_slave #(.ADDR_W(12), .WAIT(3)) u_dut_w3 (.clk(clk), .reset(rst3), .bus(b3));
  m_dm_slave #(.ADDR_W(12), .WAIT(0)) u_dut_w0 (.clk(clk), .reset(rst0), .bus(b0));

  logic        m_busy, m_ready, m_err, m_wv;
  logic [31:0] m_rdata, m_wpc, m_wa, m_wd;

  always_comb begin
    m_busy = b2.busy; m_ready = b2.ready; m_err = b2.err; m_wv = b2.wlog_valid;
    m_rdata = b2.rdata; m_wpc = b2.wlog_pc; m_wa = b2.wlog_addr; m_wd = b2.wlog_data;
    if (dut == 1) begin
      m_busy = b3.busy; m_ready = b3.ready; m_err = b3.err; m_wv = b3.wlog_valid;
      m_rdata = b3.rdata; m_wpc = b3.wlog_pc; m_wa = b3.wlog_addr; m_wd = b3.wlog_data;
    end else if (dut == 2) begin
      m_busy = b0.busy; m_ready = b0.ready; m_err = b0.err; m_wv = b0.wlog_valid;
      m_rdata = b0.rdata; m_wpc = b0.wlog_pc; m_wa = b0.wlog_addr; m_wd = b0.wlog_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Issue one request on instance sel, scramble the inputs after accept,
  // and wait (bounded) for ready. Returns at the negedge of the ready cycle.
  task automatic xact(input string tag, input int sel, input logic w, input logic [2:0] o,
                      input logic [31:0] a, input logic [31:0] d, input logic [31:0] p,
                      input int explat);
    int lat;
    tick();
    dut = sel; we = w; op = o; addr = a; wdata = d; pc = p;
    req_v = 3'b001 << sel;
    tick();
    req_v = 3'b000; we = ~w; op = 3'd7; addr = ~a; wdata = ~d; pc = ~p;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (m_ready) begin
        lat = k;
        break;
      end
      tick();
    end
    chk({tag, "_lat"}, 32'(lat), 32'(explat));
  endtask

  task automatic ld(input string tag, input int sel, input logic [2:0] o, input logic [31:0] a,
                    input logic [31:0] exp_rd, input logic exp_err, input int explat);
    xact(tag, sel, 1'b0, o, a, 32'h0, 32'h0, explat);
    chk({tag, "_rdata"}, m_rdata, exp_rd);
    chk({tag, "_err"}, {31'd0, m_err}, {31'd0, exp_err});
    chk({tag, "_wv"}, {31'd0, m_wv}, 32'd0);
  endtask

  task automatic st(input string tag, input int sel, input logic [2:0] o, input logic [31:0] a,
                    input logic [31:0] d, input logic [31:0] p, input logic exp_err,
                    input logic [31:0] exp_wd, input int explat);
    xact(tag, sel, 1'b1, o, a, d, p, explat);
    chk({tag, "_err"}, {31'd0, m_err}, {31'd0, exp_err});
    chk({tag, "_rdata"}, m_rdata, 32'd0);
    chk({tag, "_wv"}, {31'd0, m_wv}, {31'd0, ~exp_err});
    if (!exp_err) begin
      chk({tag, "_wpc"}, m_wpc, p);
      chk({tag, "_waddr"}, m_wa, {a[31:2], 2'b00});
      chk({tag, "_wdata"}, m_wd, exp_wd);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_vec = 0; n_miss = 0;
    req_v = 3'b000; we = 1'b0; op = 3'd0; addr = 32'd0; wdata = 32'd0; pc = 32'd0; dut = 0;
    rst2 = 1'b1; rst3 = 1'b1; rst0 = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("rst_busy",  {31'd0, m_busy},  32'd0);
    chk("rst_ready", {31'd0, m_ready}, 32'd0);
    chk("rst_rdata", m_rdata, 32'd0);
    chk("rst_err",   {31'd0, m_err},   32'd0);
    chk("rst_wv",    {31'd0, m_wv},    32'd0);
    chk("rst_wpc",   m_wpc, 32'd0);
    chk("rst_waddr", m_wa,  32'd0);
    chk("rst_wdata", m_wd,  32'd0);
    tick();
    rst2 = 1'b0; rst3 = 1'b0; rst0 = 1'b0;

    // WAIT=2: sw at cycle 0, then back-to-back lw accepted in the RESP cycle
    tick();
    we = 1'b1; op = 3'd0; addr = 32'h10; wdata = 32'h8765_4321; pc = 32'h3000; req_v = 3'b001;
    @(negedge clk); chk("c0_busy", {31'd0, m_busy}, 32'd0);
    tick();
    req_v = 3'b000; addr = 32'hFFFF_FFFF; wdata = 32'd0;
    @(negedge clk); chk("c1_busy", {31'd0, m_busy}, 32'd1); chk("c1_ready", {31'd0, m_ready}, 32'd0);
    tick();
    @(negedge clk); chk("c2_busy", {31'd0, m_busy}, 32'd1); chk("c2_ready", {31'd0, m_ready}, 32'd0);
    tick();
    we = 1'b0; op = 3'd0; addr = 32'h10; req_v = 3'b001;
    @(negedge clk);
    chk("c3_ready", {31'd0, m_ready}, 32'd1);
    chk("c3_busy",  {31'd0, m_busy},  32'd0);
    chk("c3_wv",    {31'd0, m_wv},    32'd1);
    chk("c3_wpc",   m_wpc, 32'h3000);
    chk("c3_waddr", m_wa,  32'h10);
    chk("c3_wdata", m_wd,  32'h8765_4321);
    chk("c3_err",   {31'd0, m_err}, 32'd0);
    tick();
    req_v = 3'b000; addr = 32'h0;
    @(negedge clk);
    chk("c4_ready", {31'd0, m_ready}, 32'd0);
    chk("c4_wv",    {31'd0, m_wv},    32'd0);
    chk("c4_busy",  {31'd0, m_busy},  32'd1);
    tick(); tick();
    @(negedge clk);
    chk("c6_ready", {31'd0, m_ready}, 32'd1);
    chk("c6_rdata", m_rdata, 32'h8765_4321);
    tick();
    @(negedge clk);
    chk("c7_rdata_hold", m_rdata, 32'h8765_4321);
    chk("c7_ready", {31'd0, m_ready}, 32'd0);

    // Load extraction
    ld("lh12",  0, 3'd1, 32'h12, 32'hFFFF_8765, 1'b0, 3);
    ld("lhu12", 0, 3'd2, 32'h12, 32'h0000_8765, 1'b0, 3);
    ld("lb11",  0, 3'd3, 32'h11, 32'h0000_0043, 1'b0, 3);
    ld("lb13",  0, 3'd3, 32'h13, 32'hFFFF_FF87, 1'b0, 3);
    ld("lbu13", 0, 3'd4, 32'h13, 32'h0000_0087, 1'b0, 3);
    ld("lh10",  0, 3'd1, 32'h10, 32'h0000_4321, 1'b0, 3);

    // Store merges
    st("sb11", 0, 3'd3, 32'h11, 32'h0000_00AB, 32'h3004, 1'b0, 32'h8765_AB21, 3);
    st("sh10", 0, 3'd1, 32'h10, 32'h0000_CAFE, 32'h3008, 1'b0, 32'h8765_CAFE, 3);
    st("sh12", 0, 3'd2, 32'h52, 32'h1234_BEEF, 32'h300C, 1'b0, 32'hBEEF_0000, 3);

    // Errors: misaligned and illegal op leave memory untouched
    ld("lw12_mis",  0, 3'd0, 32'h12, 32'h0, 1'b1, 3);
    st("sh13_mis",  0, 3'd1, 32'h13, 32'h0000_1111, 32'h3010, 1'b1, 32'h0, 3);
    st("op6_st",    0, 3'd6, 32'h10, 32'h5555_5555, 32'h3014, 1'b1, 32'h0, 3);
    ld("op6_ld",    0, 3'd6, 32'h10, 32'h0, 1'b1, 3);
    ld("lw10_after", 0, 3'd0, 32'h10, 32'h8765_CAFE, 1'b0, 3);

    // WAIT=3: reset in cycle 2 of a store aborts it
    tick();
    dut = 1; we = 1'b1; op = 3'd0; addr = 32'h20; wdata = 32'hDEAD_BEEF; pc = 32'h4000;
    req_v = 3'b010;
    tick();
    req_v = 3'b000;
    @(negedge clk); chk("ab_c1_busy", {31'd0, m_busy}, 32'd1);
    tick();
    rst3 = 1'b1;
    tick();
    rst3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ab_ready", {31'd0, m_ready}, 32'd0);
      chk("ab_busy",  {31'd0, m_busy},  32'd0);
      tick();
    end
    ld("ab_lw20", 1, 3'd0, 32'h20, 32'h0, 1'b0, 4);
    st("ab_sw24", 1, 3'd0, 32'h24, 32'h0BAD_F00D, 32'h4004, 1'b0, 32'h0BAD_F00D, 4);
    ld("ab_lw24", 1, 3'd0, 32'h24, 32'h0BAD_F00D, 1'b0, 4);

    // WAIT=0: single store, then three back-to-back loads with req held high
    st("w0_sw4", 2, 3'd0, 32'h4, 32'h1234_5678, 32'h5000, 1'b0, 32'h1234_5678, 1);
    tick();
    dut = 2; we = 1'b0; op = 3'd0; addr = 32'h0; req_v = 3'b100;
    @(negedge clk); chk("w0_a_busy", {31'd0, m_busy}, 32'd0);
    tick();
    addr = 32'h4;
    @(negedge clk);
    chk("w0_b_ready", {31'd0, m_ready}, 32'd1);
    chk("w0_b_busy",  {31'd0, m_busy},  32'd0);
    chk("w0_b_rdata", m_rdata, 32'h0);
    tick();
    addr = 32'h8;
    @(negedge clk);
    chk("w0_c_ready", {31'd0, m_ready}, 32'd1);
    chk("w0_c_busy",  {31'd0, m_busy},  32'd0);
    chk("w0_c_rdata", m_rdata, 32'h1234_5678);
    tick();
    req_v = 3'b000;
    @(negedge clk);
    chk("w0_d_ready", {31'd0, m_ready}, 32'd1);
    chk("w0_d_busy",  {31'd0, m_busy},  32'd0);
    chk("w0_d_rdata", m_rdata, 32'h0);
    tick();
    @(negedge clk);
    chk("w0_e_ready", {31'd0, m_ready}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
